sm_integ: RTL and testbench
===========================

Name: sm_integ

Overview:
- Sign-magnitude integrator. Accumulates a stream of signed deltas: Y(n) = Y(n-1) + D(n).
- It is the inverse of the anspwm delayed-difference stage. Feeding it that stage's output stream reconstructs the original sample stream exactly, as long as no saturation occurs.
- Sits on the decode side of the anspwm datapath, ahead of the PWM modulator. Carries a valid qualifier and saturation status.

Parameters:
- W, 16, magnitude width of input delta and accumulator.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- clr  input  1  synchronous accumulator clear; rst_n takes precedence over clr.
- in_valid  input  1  D/D_sign carry a delta this cycle.
- D  input  W  delta magnitude.
- D_sign  input  1  delta sign, 1 = negative.
- Y  output  W  accumulator magnitude, registered.
- Y_sign  output  1  accumulator sign, 1 = negative, registered.
- out_valid  output  1  Y/Y_sign updated by an accepted delta last cycle.
- sat_now  output  1  the update presented with this out_valid was clamped.
- sat  output  1  sticky saturation flag.
- n_samples  output  16  count of accepted deltas since reset/clr; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n=0 at posedge): Y=0, Y_sign=0, out_valid=0, sat_now=0, sat=0, n_samples=0.
- Priority per cycle: rst_n, then clr, then in_valid.
- clr=1: same values as reset. Any in_valid that cycle is dropped.
- in_valid=1 (no clr): compute the sign-magnitude sum of {Y_sign,Y} + {D_sign,D} with a W+1 bit magnitude.
  - Same signs: magnitude = Y + D, sign = common sign.
  - Differing signs: magnitude = |Y - D|; sign = sign of the larger magnitude.
  - Equal magnitudes with differing signs: result +0.
- Saturation: if the W+1 bit magnitude exceeds 2^W-1, clamp to 2^W-1 and keep the computed sign. Set sat_now=1 on the output cycle and set sat.
- Negative zero: an input D=0,D_sign=1 is treated as +0. A zero-magnitude result always has Y_sign=0.
- Latency: one cycle. Update registered at the posedge where in_valid=1. Y/Y_sign/out_valid/sat_now visible immediately after that edge.
- in_valid=0: Y/Y_sign hold; out_valid=0, sat_now=0; sat and n_samples hold.
- Back-to-back in_valid accepted every cycle; there is no backpressure.
- n_samples: +1 per accepted delta; holds at 16'hFFFF (no wrap).
- sat clears only on reset or clr.
- clr asserted in the same cycle as an overflowing delta: clr wins, sat stays 0.
- Reset mid-stream: all state is lost; the next accepted delta is added to 0.

Decomposition:
- Shared package anspwm_pkg:
  - localparam W = 16, MAG_MAX = 2^W-1.
  - typedef struct packed {bit sign; bit [W-1:0] mag;} sm_t, reused by the difference stage.
  - function sm_norm() that forces the sign to 0 when the magnitude is 0.
- One combinational sub-module sm_add (inputs: two sm_t; outputs: sm_t sum with clamped magnitude, sat flag).
- sm_integ holds the registers, valid pipeline, sticky flag and counter.

Test Plan:
- Reconstruction: in_valid each cycle, deltas +100, +50, -30, -200, +80 -> Y/sign sequence +100, +150, +120, -80, +0 (sign 0). out_valid high 1 cycle after each delta; sat=0; n_samples=5.
- Round trip: samples 0, 1000, 65535, 12, 40000 through the difference stage into sm_integ -> Y equals the original samples, one cycle after each delta output.
- Saturation: deltas +65000, +1000 -> Y=65535 sign 0, sat_now=1 for that one output cycle, sat=1. Then -535 -> Y=65000, sat_now=0, sat stays 1.
- Negative zero: delta -0 from reset -> Y=0, Y_sign=0. Then -5, +5 -> -5 then +0 (sign 0).
- Gaps and clr: +7, idle 3 cycles, +3 -> out_valid only on 2 cycles, Y=10. Then clr together with +9 -> Y=0, sat=0, n_samples=0, out_valid=0. Next +9 -> Y=9.
- Reset mid-stream: accumulate to -300 with sat=1, assert rst_n=0 for 1 cycle -> all outputs 0. Next +4 -> Y=4, n_samples=1.

Source files
------------

// File: rtl/anspwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : anspwm_pkg
//  Description : Types and helpers shared across the anspwm datapath.
//                sm_t is the sign-magnitude sample word used by the
//                difference and integration stages. sm_norm() removes
//                negative zero.
//  Revision    : 1.0  initial release
// ============================================================================
package anspwm_pkg;

    localparam int W = 16;
    localparam logic [W-1:0] MAG_MAX = '1;  // 2^W-1

    typedef struct packed {
        bit         sign;   // 1 = negative
        bit [W-1:0] mag;
    } sm_t;

    // A zero magnitude is always reported as +0.
    function automatic sm_t sm_norm(input sm_t x);
        sm_t r;
        r = x;
        if (x.mag == '0) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

endpackage : anspwm_pkg
`default_nettype wire

// File: rtl/sm_add.sv
`default_nettype none
// ============================================================================
//  Module      : sm_add
//  Description : Combinational sign-magnitude adder with a clamped
//                magnitude. The sum is formed with one extra magnitude bit.
//                If that bit is set, the magnitude is clamped to MAG_MAX and
//                the computed sign is kept.
//  Ports       : i_a, i_b  - sign-magnitude operands
//                o_sum     - normalised, clamped sum
//                o_sat     - the sum was clamped
//  Revision    : 1.0  initial release
// ============================================================================
module sm_add
    import anspwm_pkg::*;
(
    input  sm_t  i_a,
    input  sm_t  i_b,
    output sm_t  o_sum,
    output logic o_sat
);

    sm_t          w_a;
    sm_t          w_b;
    logic [W:0]   w_raw;
    logic         w_sign;
    sm_t          w_pre;

    // Normalise the operands so that -0 never controls the result sign.
    assign w_a = sm_norm(i_a);
    assign w_b = sm_norm(i_b);

    always_comb begin
        w_raw  = '0;
        w_sign = 1'b0;
        if (w_a.sign == w_b.sign) begin
            w_raw  = {1'b0, w_a.mag} + {1'b0, w_b.mag};
            w_sign = w_a.sign;
        end else if (w_a.mag >= w_b.mag) begin
            w_raw  = {1'b0, w_a.mag} - {1'b0, w_b.mag};
            w_sign = w_a.sign;
        end else begin
            w_raw  = {1'b0, w_b.mag} - {1'b0, w_a.mag};
            w_sign = w_b.sign;
        end
    end

    // An overflow can only occur when the signs match. It never reaches
    // past bit W, so bit W alone is the overflow flag.
    assign o_sat      = w_raw[W];
    assign w_pre.sign = w_sign;
    assign w_pre.mag  = o_sat ? MAG_MAX : w_raw[W-1:0];
    assign o_sum      = sm_norm(w_pre);

endmodule : sm_add
`default_nettype wire

// File: rtl/sm_integ.sv
`default_nettype none
// ============================================================================
//  Module      : sm_integ
//  Description : Sign-magnitude integrator, Y(n) = Y(n-1) + D(n), with
//                saturation. This stage inverts the anspwm delayed-difference
//                stage. Latency is one cycle, and a new delta is accepted on
//                every cycle.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                clr             - synchronous clear; rst_n has priority
//                in_valid, D, D_sign       - input delta
//                Y, Y_sign, out_valid      - registered accumulator
//                sat_now         - the current output was clamped
//                sat             - sticky saturation flag
//                n_samples       - saturating count of accepted deltas
//  Revision    : 1.0  initial release
// ============================================================================
module sm_integ #(
    parameter int W = anspwm_pkg::W     // must match anspwm_pkg::W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [W-1:0]  D,
    input  logic          D_sign,
    output logic [W-1:0]  Y,
    output logic          Y_sign,
    output logic          out_valid,
    output logic          sat_now,
    output logic          sat,
    output logic [15:0]   n_samples
);

    import anspwm_pkg::sm_t;

    sm_t          r_y;
    logic         r_out_valid;
    logic         r_sat_now;
    logic         r_sat;
    logic [15:0]  r_cnt;

    sm_t          w_d;
    sm_t          w_sum;
    logic         w_ovf;

    assign w_d.sign = D_sign;
    assign w_d.mag  = D;

    sm_add u_add (
        .i_a   (r_y),
        .i_b   (w_d),
        .o_sum (w_sum),
        .o_sat (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_sat_now   <= 1'b0;
            r_sat       <= 1'b0;
            r_cnt       <= '0;
        end else if (in_valid) begin
            r_y         <= w_sum;
            r_out_valid <= 1'b1;
            r_sat_now   <= w_ovf;
            r_sat       <= r_sat | w_ovf;
            if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_sat_now   <= 1'b0;
        end
    end

    assign Y         = r_y.mag;
    assign Y_sign    = r_y.sign;
    assign out_valid = r_out_valid;
    assign sat_now   = r_sat_now;
    assign sat       = r_sat;
    assign n_samples = r_cnt;

endmodule : sm_integ
`default_nettype wire

// File: tb/tb_sm_integ.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_integ
//  Description : Self-checking bench for sm_integ. A signed-integer
//                reference model pushes the expected outputs into a queue.
//                A separate monitor pops each entry and compares it against
//                the DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sm_integ;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  D = '0;
    logic          D_sign = 1'b0;
    logic [W-1:0]  Y;
    logic          Y_sign;
    logic          out_valid;
    logic          sat_now;
    logic          sat;
    logic [15:0]   n_samples;

    sm_integ #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .D         (D),
        .D_sign    (D_sign),
        .Y         (Y),
        .Y_sign    (Y_sign),
        .out_valid (out_valid),
        .sat_now   (sat_now),
        .sat       (sat),
        .n_samples (n_samples)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: plain signed integer ----------------
    typedef struct {
        int mag;
        bit sgn;
        bit satn;
        bit sat;
        int n;
    } exp_t;

    exp_t q[$];
    int   m_acc = 0;
    bit   m_sat = 0;
    int   m_n   = 0;

    always @(posedge clk) begin
        int  d;
        int  s;
        bit  c;
        exp_t e;
        if (!rst_n || clr) begin
            m_acc = 0;
            m_sat = 0;
            m_n   = 0;
        end else if (in_valid) begin
            d = D_sign ? -int'(D) : int'(D);
            s = m_acc + d;
            c = 0;
            if (s > 65535)  begin s = 65535;  c = 1; end
            if (s < -65535) begin s = -65535; c = 1; end
            m_acc = s;
            if (c) m_sat = 1;
            if (m_n < 65535) m_n++;
            e.mag  = (s < 0) ? -s : s;
            e.sgn  = (s < 0);
            e.satn = c;
            e.sat  = m_sat;
            e.n    = m_n;
            q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("Y",         Y,         e.mag);
                chk("Y_sign",    Y_sign,    e.sgn);
                chk("sat_now",   sat_now,   e.satn);
                chk("sat",       sat,       e.sat);
                chk("n_samples", n_samples, e.n);
            end
        end else begin
            // Idle cycle: outputs hold the model state and sat_now is low.
            chk("idle_sat_now", sat_now, 0);
            chk("idle_Y",       Y,       (m_acc < 0) ? -m_acc : m_acc);
            chk("idle_Y_sign",  Y_sign,  (m_acc < 0));
            chk("idle_sat",     sat,     m_sat);
            chk("idle_n",       n_samples, m_n);
        end
    end

    // Drive one cycle; returns 1 time unit after the active edge.
    task automatic drive(input bit v, input bit s, input int m,
                         input bit c = 0, input bit r = 0);
        in_valid = v;
        D_sign   = s;
        D        = W'(m);
        clr      = c;
        rst_n    = !r;
        @(posedge clk);
        #1;
        in_valid = 0;
        clr      = 0;
        rst_n    = 1;
    endtask

    task automatic delta(input int v, input bit c = 0);
        drive(1, v < 0, (v < 0) ? -v : v, c, 0);
    endtask

    task automatic chk_y(input string name, input int v);
        chk({name, "_Y"},    Y,      (v < 0) ? -v : v);
        chk({name, "_sign"}, Y_sign, (v < 0));
    endtask

    int rt_samples[5] = '{0, 1000, 65535, 12, 40000};

    initial begin
        int prev;
        // Reset
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("rst_Y", Y, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat", sat, 0);
        chk("rst_n_samples", n_samples, 0);

        // Reconstruction
        delta(100);  chk_y("rec1", 100);
        delta(50);   chk_y("rec2", 150);
        delta(-30);  chk_y("rec3", 120);
        delta(-200); chk_y("rec4", -80);
        delta(80);   chk_y("rec5", 0);
        chk("rec_n", n_samples, 5);
        chk("rec_sat", sat, 0);
        chk("rec_valid", out_valid, 1);

        // Round trip through the difference rule
        drive(0, 0, 0, 1, 0);
        prev = 0;
        foreach (rt_samples[i]) begin
            delta(rt_samples[i] - prev);
            chk_y("roundtrip", rt_samples[i]);
            prev = rt_samples[i];
        end

        // Saturation
        drive(0, 0, 0, 1, 0);
        delta(65000);
        delta(1000);
        chk_y("sat1", 65535);
        chk("sat1_sat_now", sat_now, 1);
        chk("sat1_sat", sat, 1);
        delta(-535);
        chk_y("sat2", 65000);
        chk("sat2_sat_now", sat_now, 0);
        chk("sat2_sat", sat, 1);

        // Negative zero
        drive(0, 0, 0, 0, 1);
        drive(1, 1, 0);
        chk_y("negz", 0);
        delta(-5); chk_y("negz2", -5);
        delta(5);  chk_y("negz3", 0);

        // Gaps and clr
        drive(0, 0, 0, 1, 0);
        delta(7);
        drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
        delta(3);  chk_y("gap", 10);
        delta(9, 1);
        chk_y("clr", 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_n", n_samples, 0);
        chk("clr_sat", sat, 0);
        delta(9);  chk_y("after_clr", 9);

        // clr together with an overflowing delta
        delta(65530);
        delta(100, 1);
        chk("clr_ovf_sat", sat, 0);

        // Reset mid-stream
        delta(-65000); delta(-1000); delta(65235);
        chk_y("pre_rst", -300);
        chk("pre_rst_sat", sat, 1);
        drive(0, 0, 0, 0, 1);
        chk_y("mid_rst", 0);
        chk("mid_rst_sat", sat, 0);
        delta(4);
        chk_y("post_rst", 4);
        chk("post_rst_n", n_samples, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit v;
            bit s;
            int m;
            v = ($urandom_range(0, 3) != 0);
            s = $urandom_range(0, 1);
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60000, 65535))
                                            : int'($urandom_range(0, 400));
            drive(v, s, m, ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
        end

        drive(0, 0, 0); drive(0, 0, 0);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sm_integ
`default_nettype wire
